wb_uart_rx: RTL and testbench

- Wishbone-slave UART receiver, 8N1, LSB first; the receive-side counterpart of the SoC's transmit-only UART peripheral.
- Samples `uart_rx_i` and assembles bytes, buffering them for software reads over the Wishbone bus.
- Reports frame and overrun errors.
- Sits on a slave port of the SoC Wishbone mux, alongside the timer, RAM and UART-TX slaves.

---
 rtl/wb_uart_rx.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_wb_uart_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_rx.sv
// ---------------------------------------------------------------------------
// wb_uart_rx -- Wishbone-slave UART receiver (8N1, LSB first).
//
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry circular FIFO.
// Without it a single-byte holding register buffers received data.
//
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   wb_addr_i           byte address, only [3:2] decoded
//   wb_data_i           write data
//   wb_sel_i            byte lanes, ignored (registers are word-wide)
//   wb_we_i, wb_stb_i,
//   wb_cyc_i            Wishbone control
//   wb_ack_o            one ack per access
//   wb_data_o           registered read data
//   uart_rx_i           asynchronous serial line, idle high
//   rx_irq_o            high while the receive buffer is non-empty
//
// Registers (addr[3:2]):
//   0 DATA    read pops head byte in [7:0]; 0 when empty; writes ignored
//   1 STATUS  [0] not_empty [1] overrun (W1C) [2] frame_err (W1C) [3] full
//   2,3       read 0, writes ignored
// ---------------------------------------------------------------------------
module wb_uart_rx #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int CLKS_PER_BIT  = 16,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic                     uart_rx_i,
    output logic                     rx_irq_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ---------------- line synchronizer and falling-edge detect -------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_sync;

    // ---------------- receive FSM -------------------------------------------
    state_t     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_bit, w_bit_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       w_push;
    logic       w_frame_set;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rx_sync) begin
                        // line back high at mid start bit: glitch
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_push      = r_rx_sync;
                    w_frame_set = ~r_rx_sync;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- bus decode --------------------------------------------
    logic       r_ack;
    logic [1:0] w_addr;
    logic       w_access;
    logic       w_rd;
    logic       w_wr;
    logic       w_pop;
    logic       w_wr_en;
    logic       w_not_empty;
    logic       w_full;
    logic [7:0] w_head;
    logic       w_unused;

    assign w_addr   = wb_addr_i[3:2];
    assign w_access = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_rd     = w_access & ~wb_we_i;
    assign w_wr     = w_access & wb_we_i;
    assign w_pop    = w_rd & (w_addr == 2'd0) & w_not_empty;
    // a push into a full buffer still lands when a pop frees a slot that cycle
    assign w_wr_en  = w_push & (~w_full | w_pop);
    assign w_unused = ^{wb_sel_i, wb_addr_i, wb_data_i};

    // ---------------- receive buffer ----------------------------------------
`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_valid;

    assign w_not_empty = r_valid;
    assign w_full      = r_valid;
    assign w_head      = r_hold;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else if (w_wr_en) begin
            r_hold  <= r_shift;
            r_valid <= 1'b1;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end
`endif

    // ---------------- sticky flags ------------------------------------------
    logic r_ovr;
    logic r_fe;
    logic w_ovr_set;
    logic w_clr_ovr;
    logic w_clr_fe;

    assign w_ovr_set = w_push & ~w_wr_en;
    assign w_clr_ovr = w_wr & (w_addr == 2'd1) & wb_data_i[1];
    assign w_clr_fe  = w_wr & (w_addr == 2'd1) & wb_data_i[2];

    // set takes priority over a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            r_ovr <= w_ovr_set   | (r_ovr & ~w_clr_ovr);
            r_fe  <= w_frame_set | (r_fe  & ~w_clr_fe);
        end
    end

    // ---------------- read data and ack -------------------------------------
    logic [WB_DATA_WIDTH-1:0] w_rdata;
    logic [WB_DATA_WIDTH-1:0] r_dat;

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            2'd0: begin
                if (w_not_empty) begin
                    w_rdata[7:0] = w_head;
                end
            end
            2'd1: begin
                w_rdata[3:0] = {w_full, r_fe, r_ovr, w_not_empty};
            end
            default: begin
                w_rdata = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_access;
            r_dat <= w_rd ? w_rdata : '0;
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_data_o = r_dat;
    assign rx_irq_o  = w_not_empty;

endmodule

// File: tb/tb_wb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_wb_uart_rx -- directed self-checking bench for wb_uart_rx at
// CLKS_PER_BIT = 16. Serial frames are driven one bit per 16 clocks with no
// gap between back-to-back frames. Follows UART_RX_FIFO_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_wb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        ack;
    logic [31:0] rdata;
    logic        rx = 1'b1;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_uart_rx #(
        .WB_DATA_WIDTH(32),
        .WB_ADDR_WIDTH(32),
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_addr_i(addr),
        .wb_data_i(wdata),
        .wb_sel_i (4'hF),
        .wb_we_i  (we),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_ack_o (ack),
        .wb_data_o(rdata),
        .uart_rx_i(rx),
        .rx_irq_o (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One Wishbone access; the ack wait is bounded to 4 cycles.
    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; addr = {28'd0, a, 2'b00}; wdata = wd;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                rd  = rdata;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        check("bus_ack", {31'd0, got}, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, a, '0, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] d;
        wb_xfer(1'b1, a, wd, d);
    endtask

    // Drives one 160-cycle frame starting at the next falling clock edge.
    // Iteration c runs just after falling edge c; rising edge c lies before it.
    // rd_at >= 0: start a DATA read at iteration rd_at (captured at rd_at+1).
    // rst_at >= 0: pulse reset at iteration rst_at; outputs snapshot at +1.
    task automatic send(input logic [7:0] b, input logic stop, input int rd_at, input int rst_at,
                        output logic [31:0] irq154, output logic [31:0] irq155,
                        output logic [31:0] rdat, output logic [31:0] snap);
        logic [9:0] bits;
        bits   = {stop, b, 1'b0};
        irq154 = '0; irq155 = '0; rdat = '0; snap = '1;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (c == 154) irq154 = {31'd0, irq};
            if (c == 155) irq155 = {31'd0, irq};
            if (rd_at >= 0 && c == rd_at + 1) begin
                rdat = ack ? rdata : 32'hDEAD_BEEF;
                stb = 1'b0; cyc = 1'b0;
            end
            if (c == rd_at) begin
                stb = 1'b1; cyc = 1'b1; we = 1'b0; addr = '0;
            end
            if (c == rst_at) rst = 1'b1;
            if (rst_at >= 0 && c == rst_at + 1) begin
                rst  = 1'b0;
                snap = {29'd0, irq, ack, |rdata};
            end
            rx = bits[c / 16];
        end
    endtask

    task automatic send_plain(input logic [7:0] b);
        logic [31:0] a0, a1, a2, a3;
        send(b, 1'b1, -1, -1, a0, a1, a2, a3);
    endtask

    logic [31:0] i154, i155, rd, sn;

    initial begin
        // ---- reset ----
        repeat (4) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_data", rdata, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rd_chk("rst_status", 2'd1, 32'h0);
        rd_chk("reg2", 2'd2, 32'h0);

        // ---- 0xA5 with irq latency ----
        send(8'hA5, 1'b1, -1, -1, i154, i155, rd, sn);
        check("a5_irq_early", i154, 32'd0);
        check("a5_irq_rise", i155, 32'd1);
        rd_chk("a5_status_full", 2'd1, 32'h0000_0001 | (`ifdef UART_RX_FIFO_EN 32'h0 `else 32'h8 `endif));
        rd_chk("a5_data", 2'd0, 32'h0000_00A5);
        rd_chk("a5_status_after", 2'd1, 32'h0);
        check("a5_irq_after", {31'd0, irq}, 32'd0);
        rd_chk("empty_data", 2'd0, 32'h0);

        // ---- short low glitch ----
        @(negedge clk); rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        rd_chk("glitch_status", 2'd1, 32'h0);
        send_plain(8'h5A);
        rd_chk("post_glitch_data", 2'd0, 32'h0000_005A);

        // ---- framing error ----
        send(8'h3C, 1'b0, -1, -1, i154, i155, rd, sn);
        @(negedge clk); rx = 1'b1;
        repeat (20) @(negedge clk);
        rd_chk("fe_status", 2'd1, 32'h4);
        check("fe_irq", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'h4);
        rd_chk("fe_cleared", 2'd1, 32'h0);

        // ---- overrun ----
`ifdef UART_RX_FIFO_EN
        for (int k = 1; k <= 9; k++) send_plain(8'(k));
        rd_chk("ovr_status", 2'd1, 32'hB);
        for (int k = 1; k <= 8; k++) rd_chk("ovr_data", 2'd0, 32'(k));
`else
        send_plain(8'h11);
        send_plain(8'h22);
        rd_chk("ovr_status", 2'd1, 32'hB);
        rd_chk("ovr_data", 2'd0, 32'h11);
`endif
        rd_chk("ovr_empty_data", 2'd0, 32'h0);
        rd_chk("ovr_sticky", 2'd1, 32'h2);
        wr(2'd1, 32'h2);
        rd_chk("ovr_cleared", 2'd1, 32'h0);

        // ---- full buffer, pop coinciding with push ----
`ifdef UART_RX_FIFO_EN
        for (int k = 0; k < 8; k++) send_plain(8'(8'h40 + k));
        send(8'h48, 1'b1, 154, -1, i154, i155, rd, sn);
        check("coinc_pop_data", rd, 32'h40);
        rd_chk("coinc_status", 2'd1, 32'h9);
        for (int k = 1; k <= 8; k++) rd_chk("coinc_order", 2'd0, 32'(8'h40 + k));
`else
        send_plain(8'h33);
        send(8'h44, 1'b1, 154, -1, i154, i155, rd, sn);
        check("coinc_pop_data", rd, 32'h33);
        rd_chk("coinc_status", 2'd1, 32'h9);
        rd_chk("coinc_order", 2'd0, 32'h44);
`endif
        rd_chk("coinc_final_status", 2'd1, 32'h0);

        // ---- reset mid-frame ----
        send(8'h3C, 1'b0, -1, -1, i154, i155, rd, sn);
        @(negedge clk); rx = 1'b1;
        repeat (20) @(negedge clk);
        send_plain(8'h77);
        rd_chk("pre_rst_status", 2'd1, 32'h5 | (`ifdef UART_RX_FIFO_EN 32'h0 `else 32'h8 `endif));
        send(8'hFF, 1'b1, -1, 80, i154, i155, rd, sn);
        check("midrst_outputs", sn, 32'h0);
        repeat (40) @(negedge clk);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        rd_chk("midrst_status", 2'd1, 32'h0);
        send_plain(8'h96);
        rd_chk("post_rst_data", 2'd0, 32'h96);
        rd_chk("post_rst_status", 2'd1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
